// File: rtl/bist_pkg.sv
// Shared definitions for the March C- memory BIST sequencer.
// Holds the FSM encoding, element indices and per-element operation table.
package bist_pkg;

    localparam int unsigned ELEM_W   = 3;
    localparam int unsigned N_ELEMS  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ELEM_W-1:0] E0 = 3'd0;
    localparam logic [ELEM_W-1:0] E1 = 3'd1;
    localparam logic [ELEM_W-1:0] E2 = 3'd2;
    localparam logic [ELEM_W-1:0] E3 = 3'd3;
    localparam logic [ELEM_W-1:0] E4 = 3'd4;
    localparam logic [ELEM_W-1:0] E5 = 3'd5;

    // Element table, one bit per element index:
    // E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
    localparam logic [N_ELEMS-1:0] ELEM_DOWN   = 6'b011000;
    localparam logic [N_ELEMS-1:0] ELEM_HAS_RD = 6'b111110;
    localparam logic [N_ELEMS-1:0] ELEM_HAS_WR = 6'b011111;
    localparam logic [N_ELEMS-1:0] ELEM_RD_VAL = 6'b010100;
    localparam logic [N_ELEMS-1:0] ELEM_WR_VAL = 6'b001010;

endpackage

// File: rtl/bist_addr_ctr.sv
// Up/down address counter for the March sequencer.
// Load presets the start address for the chosen direction; c_out flags the terminal address.
module bist_addr_ctr #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_load_down,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_cnt,
    output logic              c_out
);

    logic [ADDR_W-1:0] r_cnt;
    logic              r_down;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= i_load_down ? '1 : '0;
            r_down <= i_load_down;
        end else if (i_en) begin
            r_cnt  <= r_down ? (r_cnt - ADDR_W'(1)) : (r_cnt + ADDR_W'(1));
        end
    end

    assign o_cnt = r_cnt;
    assign c_out = r_down ? (r_cnt == '0) : (r_cnt == '1);

endmodule

// File: rtl/bist_march_seq.sv
// March C- BIST sequencer: one memory op per cycle, read compare one cycle later,
// first-mismatch capture and early termination.
module bist_march_seq
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    state_t              r_state;
    state_t              w_nxt_state;
    logic [ELEM_W-1:0]   r_elem;
    logic [ELEM_W-1:0]   w_nxt_elem;
    logic [ELEM_W-1:0]   w_elem_inc;
    logic                r_phase;
    logic                w_nxt_phase;
    logic                w_issue;
    logic                w_start_ok;
    logic                w_mismatch;

    logic                w_ctr_load;
    logic                w_ctr_load_down;
    logic                w_ctr_en;
    logic                w_ctr_tc;
    logic [ADDR_W-1:0]   w_ctr_cnt;

    logic                w_nxt_we;
    logic                w_nxt_re;
    logic [DATA_W-1:0]   w_nxt_wdata;
    logic [DATA_W-1:0]   w_nxt_exp;

    logic                r_we;
    logic                r_re;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_exp;
    logic                r_cmp_pend;
    logic [DATA_W-1:0]   r_cmp_exp;
    logic [ADDR_W-1:0]   r_cmp_addr;
    logic [ELEM_W-1:0]   r_cmp_elem;
    logic                r_busy;
    logic                r_done;
    logic                r_fail;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [ELEM_W-1:0]   r_fail_elem;

    bist_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_ctr_load),
        .i_load_down (w_ctr_load_down),
        .i_en        (w_ctr_en),
        .o_cnt       (w_ctr_cnt),
        .c_out       (w_ctr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nxt_state;
    end

    // Sequencing: advance phase, address, or element after each issued op.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_elem      = r_elem;
        w_nxt_phase     = r_phase;
        w_issue         = 1'b0;
        w_ctr_load      = 1'b0;
        w_ctr_load_down = 1'b0;
        w_ctr_en        = 1'b0;
        w_elem_inc      = r_elem + ELEM_W'(1);
        w_start_ok      = (r_state == ST_IDLE || r_state == ST_DONE) && start;
        w_mismatch      = r_cmp_pend && (mem_rdata != r_cmp_exp);

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_nxt_state     = ST_RUN;
                    w_nxt_elem      = E0;
                    w_nxt_phase     = 1'b0;
                    w_issue         = 1'b1;
                    w_ctr_load      = 1'b1;
                    w_ctr_load_down = ELEM_DOWN[E0];
                end
            end
            ST_RUN: begin
                if (w_mismatch) begin
                    w_nxt_state = ST_DONE;
                end else if (ELEM_HAS_RD[r_elem] && ELEM_HAS_WR[r_elem] && !r_phase) begin
                    w_nxt_phase = 1'b1;
                    w_issue     = 1'b1;
                end else if (!w_ctr_tc) begin
                    w_nxt_phase = 1'b0;
                    w_ctr_en    = 1'b1;
                    w_issue     = 1'b1;
                end else if (r_elem == E5) begin
                    w_nxt_state = ST_DRAIN;
                end else begin
                    w_nxt_elem      = w_elem_inc;
                    w_nxt_phase     = 1'b0;
                    w_issue         = 1'b1;
                    w_ctr_load      = 1'b1;
                    w_ctr_load_down = ELEM_DOWN[w_elem_inc];
                end
            end
            ST_DRAIN: w_nxt_state = ST_DONE;
            default:  w_nxt_state = ST_IDLE;
        endcase
    end

    // Decode the op to be presented next cycle from the next element/phase.
    always_comb begin
        w_nxt_re    = w_issue && ELEM_HAS_RD[w_nxt_elem] && !w_nxt_phase;
        w_nxt_we    = w_issue && !w_nxt_re;
        w_nxt_wdata = (w_nxt_we && ELEM_WR_VAL[w_nxt_elem]) ? '1 : '0;
        w_nxt_exp   = ELEM_RD_VAL[w_nxt_elem] ? '1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elem      <= '0;
            r_phase     <= 1'b0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_wdata     <= '0;
            r_exp       <= '0;
            r_cmp_pend  <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
        end else begin
            r_elem     <= w_nxt_elem;
            r_phase    <= w_nxt_phase;
            r_we       <= w_nxt_we;
            r_re       <= w_nxt_re;
            r_wdata    <= w_nxt_wdata;
            if (w_nxt_re) r_exp <= w_nxt_exp;
            // Capture the read in flight so it is compared when its data returns.
            r_cmp_pend <= r_re && (w_nxt_state == ST_RUN || w_nxt_state == ST_DRAIN);
            r_cmp_exp  <= r_exp;
            r_cmp_addr <= w_ctr_cnt;
            r_cmp_elem <= r_elem;
            r_busy     <= (w_nxt_state == ST_RUN || w_nxt_state == ST_DRAIN);
            r_done     <= (w_nxt_state == ST_DONE);
            if (w_start_ok) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_elem <= '0;
            end else if (w_mismatch && !r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_cmp_addr;
                r_fail_elem <= r_cmp_elem;
            end
        end
    end

    assign mem_addr  = w_ctr_cnt;
    assign mem_we    = r_we;
    assign mem_re    = r_re;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;

endmodule

// File: tb/tb_bist_march_seq.sv
// Bench for bist_march_seq: 1-cycle-latency memory with stuck-at faults and a
// March C- reference model that predicts the full op trace and fail capture.
module tb_bist_march_seq;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int          N      = 16;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;

    bist_march_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    // Memory with per-address stuck-at-1 / stuck-at-0 masks applied on read.
    logic [DATA_W-1:0] mem [N];
    logic [DATA_W-1:0] s1  [N];
    logic [DATA_W-1:0] s0  [N];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= (mem[mem_addr] | s1[mem_addr]) & ~s0[mem_addr];
    end

    typedef struct packed {
        logic              we;
        logic              re;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    int  cyc = 0;
    int  busy_cnt;
    int  both_cnt;
    bit  mon_en = 1'b0;
    op_t got_q[$];
    int  got_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        op_t o;
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (mem_we && mem_re) both_cnt++;
            if (mem_we || mem_re) begin
                o.we   = mem_we;
                o.re   = mem_re;
                o.addr = mem_addr;
                o.data = mem_we ? mem_wdata : '0;
                got_q.push_back(o);
                got_cyc.push_back(cyc);
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk March C- over a faulty memory, find the first failing read.
    op_t ref_q[$];
    bit  ref_fail;
    int  ref_fail_addr;
    int  ref_fail_elem;
    int  ref_busy;

    task automatic build_ref();
        logic [DATA_W-1:0] fm [N];
        int  nops [6] = '{1, 2, 2, 2, 2, 1};
        bit  dn   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int  code [6][2] = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};
        int  idx, k, a, c;
        logic [DATA_W-1:0] v, pat;
        op_t o;
        ref_q.delete();
        ref_fail = 1'b0;
        ref_fail_addr = 0;
        ref_fail_elem = 0;
        idx = 0;
        k = -1;
        for (int i = 0; i < N; i++) fm[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                a = dn[e] ? (N - 1 - i) : i;
                for (int j = 0; j < nops[e]; j++) begin
                    c = code[e][j];
                    pat = (c % 2 == 1) ? '1 : '0;
                    o.we   = (c >= 2);
                    o.re   = (c < 2);
                    o.addr = ADDR_W'(a);
                    o.data = o.we ? pat : '0;
                    ref_q.push_back(o);
                    if (o.we) begin
                        fm[a] = pat;
                    end else if (!ref_fail) begin
                        v = (fm[a] | s1[a]) & ~s0[a];
                        if (v != pat) begin
                            ref_fail = 1'b1;
                            k = idx;
                            ref_fail_addr = a;
                            ref_fail_elem = e;
                        end
                    end
                    idx++;
                end
            end
        end
        if (ref_fail) begin
            ref_busy = (k == idx - 1) ? idx + 1 : k + 2;
            while (ref_q.size() > k + 2) void'(ref_q.pop_back());
        end else begin
            ref_busy = idx + 1;
        end
    endtask

    function automatic logic [ADDR_W-1:0] addr_at(input int i);
        if (i < got_q.size()) return got_q[i].addr;
        return 'x;
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            s1[i] = '0;
            s0[i] = '0;
        end
    endtask

    task automatic run_and_check(input string tag, input int pulse_at,
                                 output int o_busy, output int o_nw, output int o_nr);
        int waited, start_cyc, base, lim;
        build_ref();
        got_q.delete();
        got_cyc.delete();
        busy_cnt = 0;
        both_cnt = 0;
        mon_en   = 1'b1;
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " clear_on_start"}, 32'({done, fail, fail_addr, fail_elem}), 32'd0);
        chk({tag, " busy_on_start"}, 32'(busy), 32'd1);
        waited = 0;
        while (!done && waited < 4000) begin
            @(negedge clk);
            waited++;
            start = (pulse_at > 0 && waited == pulse_at);
        end
        start = 1'b0;
        chk({tag, " done_reached"}, 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(ref_busy));
        chk({tag, " fail"}, 32'(fail), 32'(ref_fail));
        chk({tag, " fail_addr"}, 32'(fail_addr), 32'(ref_fail_addr));
        chk({tag, " fail_elem"}, 32'(fail_elem), 32'(ref_fail_elem));
        chk({tag, " we_re_overlap"}, 32'(both_cnt), 32'd0);
        chk({tag, " op_count"}, 32'(got_q.size()), 32'(ref_q.size()));
        o_nw = 0;
        o_nr = 0;
        foreach (got_q[i]) begin
            if (got_q[i].we) o_nw++;
            if (got_q[i].re) o_nr++;
        end
        lim  = (got_q.size() < ref_q.size()) ? got_q.size() : ref_q.size();
        base = n_fail;
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("%s op%0d", tag, i), 32'(got_q[i]), 32'(ref_q[i]));
            chk($sformatf("%s slot%0d", tag, i), 32'(got_cyc[i]), 32'(start_cyc + i));
            if (n_fail != base) break;
        end
        o_busy = busy_cnt;
    endtask

    initial begin
        int b, nw, nr, waited, fa, fm_sel;
        logic [DATA_W-1:0] msk;
        clear_faults();

        #1 rst = 1'b1;
        #11;
        chk("reset_outputs", 32'({mem_addr, mem_we, mem_re, mem_wdata, busy, done, fail,
                                  fail_addr, fail_elem}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_busy", 32'({busy, done, mem_we, mem_re}), 32'd0);

        // Fault-free run.
        run_and_check("clean", 0, b, nw, nr);
        chk("clean busy161", 32'(b), 32'd161);
        chk("clean writes80", 32'(nw), 32'd80);
        chk("clean reads80", 32'(nr), 32'd80);
        chk("clean done_pass", 32'({done, fail}), 32'b10);
        chk("e3_first_addr", 32'(addr_at(80)), 32'd15);
        chk("e3_last_addr", 32'(addr_at(111)), 32'd0);
        chk("e4_first_addr", 32'(addr_at(112)), 32'd15);
        chk("e4_last_addr", 32'(addr_at(143)), 32'd0);

        // Bit 0 of address 5 stuck at 1.
        s1[5] = 8'h01;
        run_and_check("sa1_a5", 0, b, nw, nr);
        chk("sa1_a5 fail_addr5", 32'(fail_addr), 32'd5);
        chk("sa1_a5 fail_elem1", 32'(fail_elem), 32'd1);
        chk("sa1_a5 ops_stop", 32'(nw + nr), 32'd28);
        clear_faults();

        // Rerun from DONE after a fail: clears and passes.
        run_and_check("rerun", 0, b, nw, nr);
        chk("rerun busy161", 32'(b), 32'd161);

        // Address 9 stuck at 0.
        s0[9] = 8'hFF;
        run_and_check("sa0_a9", 0, b, nw, nr);
        chk("sa0_a9 fail", 32'(fail), 32'd1);
        chk("sa0_a9 fail_addr9", 32'(fail_addr), 32'd9);
        chk("sa0_a9 fail_elem2", 32'(fail_elem), 32'd2);
        clear_faults();

        // start pulsed mid-run is ignored.
        run_and_check("pulse", int'($urandom_range(2, 150)), b, nw, nr);
        chk("pulse busy161", 32'(b), 32'd161);

        // Asynchronous reset in the middle of E2.
        got_q.delete();
        got_cyc.delete();
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (got_q.size() < 55 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid_e2 reached", 32'(got_q.size() >= 55), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({mem_addr, mem_we, mem_re, mem_wdata, busy, done, fail,
                                      fail_addr, fail_elem}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        got_cyc.delete();
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        chk("rst_waits_start ops", 32'(got_q.size()), 32'd0);
        chk("rst_waits_start flags", 32'({busy, done}), 32'd0);
        run_and_check("after_rst", 0, b, nw, nr);
        chk("after_rst busy161", 32'(b), 32'd161);

        // Randomized single-address stuck-at faults.
        for (int t = 0; t < 6; t++) begin
            clear_faults();
            fa     = int'($urandom_range(0, N - 1));
            msk    = DATA_W'($urandom_range(1, 255));
            fm_sel = int'($urandom_range(0, 1));
            if (fm_sel == 1) s1[fa] = msk;
            else             s0[fa] = msk;
            run_and_check($sformatf("rnd%0d", t), 0, b, nw, nr);
        end
        clear_faults();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_march_seq.md
BIST_MARCH_SEQ -- requirements
Module: bist_march_seq

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, memory address width; N = 2^ADDR_W words.
REQ-002 SHALL provide parameter DATA_W, default 8, memory word width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports: clk and rst.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit: test request, sampled only in IDLE or DONE.
REQ-007 SHALL have port mem_rdata, input, DATA_W bits: memory read data, valid one cycle after mem_re.
REQ-008 SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-009 SHALL have port mem_we, output, 1 bit: write strobe.
REQ-010 SHALL have port mem_re, output, 1 bit: read strobe.
REQ-011 SHALL have port mem_wdata, output, DATA_W bits: write pattern.
REQ-012 SHALL have port busy, output, 1 bit: test in progress.
REQ-013 SHALL have port done, output, 1 bit: test finished (level).
REQ-014 SHALL have port fail, output, 1 bit: mismatch detected (level, valid with done).
REQ-015 SHALL have port fail_addr, output, ADDR_W bits: address of the first mismatch.
REQ-016 SHALL have port fail_elem, output, 3 bits: March element index of the first mismatch.

Function
REQ-017 SHALL run March C- as elements 0..5: E0 any(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 any(r0). E0 and E5 SHALL run up.
REQ-018 Pattern 0 SHALL be all zeros and pattern 1 all ones over DATA_W bits.
REQ-019 SHALL issue exactly one memory op per cycle: single-op elements take 1 cycle per address; two-op elements take read then write on the same address in consecutive cycles.
REQ-020 Up elements SHALL visit addresses 0..N-1; down elements SHALL visit N-1..0. The next element SHALL begin on the cycle after the last op at the terminal address, with no idle cycle.
REQ-021 The FSM SHALL have states IDLE, RUN, DRAIN and DONE. IDLE or DONE with start=1 SHALL go to RUN. RUN SHALL go to DRAIN after the last E5 read. DRAIN SHALL go to DONE after 1 cycle.
REQ-022 The first op (E0 write, address 0) SHALL be issued in the cycle after start is sampled.
REQ-023 Each read SHALL register an expected value and compare it with mem_rdata in the following cycle. A compare still pending in DRAIN SHALL be evaluated.
REQ-024 On the first mismatch, the block SHALL latch fail=1, fail_addr and fail_elem, and go to DONE in the next cycle. An op issued in the same cycle as the compare SHALL still complete. No further ops SHALL be issued.
REQ-025 busy SHALL be 1 in RUN and DRAIN. A fault-free run SHALL keep busy high for exactly 10N+1 cycles.
REQ-026 done SHALL be 1 only in DONE, held until the next start.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 Start from DONE SHALL clear done, fail, fail_addr and fail_elem in the same edge that enters RUN.
REQ-029 mem_we and mem_re SHALL never be high together. Both SHALL be 0 outside RUN.

Reset
REQ-030 rst SHALL force state to IDLE immediately, irrespective of clk.
REQ-031 rst SHALL force every output to 0 immediately, irrespective of clk, including mid-run.
REQ-032 rst SHALL discard any pending compare. After rst deasserts, the block SHALL wait for a new start.

Structure
REQ-033 Package bist_pkg SHALL hold the FSM state encoding, the March element index constants (E0..E5), and the per-element direction/op table.
REQ-034 The address generator SHALL be a sub-module bist_addr_ctr: an up/down counter with load-to-start-address input and a terminal-count output c_out.

Verification (ADDR_W=4, DATA_W=8, 1-cycle-latency memory model)
REQ-035 Fault-free run: start for 1 cycle -> busy high for exactly 161 cycles, 80 writes, 80 reads, then done=1 and fail=0.
REQ-036 Bit 0 of address 5 stuck-at-1 -> fail=1, fail_addr=5, fail_elem=1, and no mem_we/mem_re after the compare cycle.
REQ-037 Address 9 stuck-at-0 (all bits) -> fail=1, fail_addr=9, fail_elem=2.
REQ-038 Address trace check -> E3 and E4 start at address 15 and end at 0; each element begins with no gap.
REQ-039 rst asserted mid-E2 -> all outputs 0 without a clock edge; a new start afterwards gives a full 161-cycle pass.
REQ-040 start pulsed during RUN -> ignored, with identical cycle count. start in DONE after a fail -> fail cleared and the test reruns.
